// File: rtl/fpu_pkg.sv
// -----------------------------------------------------------------------------
// fpu_pkg
// Shared definitions for the FPU command sequencer:
//   - opcode encoding (OP_FCLASS .. OP_SQRT)
//   - sequencer FSM state encodings (IDLE / ISSUE / WAIT)
//   - default exception flag width and the last legal opcode value
// The width-parametrised command/result entry structs live in the top module
// because their field widths follow that module's parameters.
// -----------------------------------------------------------------------------
package fpu_pkg;

  // Exception flag vector width, ordered {NV, DZ, OF, UF, NX}.
  localparam int EXC_W = 5;

  typedef enum logic [3:0] {
    OP_FCLASS = 4'd0,
    OP_SINJ   = 4'd1,
    OP_CMP    = 4'd2,
    OP_MINMAX = 4'd3,
    OP_I2F    = 4'd4,
    OP_F2I    = 4'd5,
    OP_ADDSUB = 4'd6,
    OP_MUL    = 4'd7,
    OP_FMA    = 4'd8,
    OP_DIV    = 4'd9,
    OP_SQRT   = 4'd10
  } fpu_op_e;

  // Highest opcode the datapath implements; anything above is illegal.
  localparam int OP_LAST = 10;

  // Sequencer FSM encodings.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

endpackage : fpu_pkg

// File: rtl/fpu_sync_fifo.sv
// -----------------------------------------------------------------------------
// fpu_sync_fifo
// Single-clock FIFO with register storage. Pointers carry one extra wrap bit so
// full/empty are told apart by comparing the MSBs. Storage is cleared on reset
// so the head word reads as zero until something is written.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   wr_en, wr_data  write request; ignored while full
//   rd_en           pop request; ignored while empty
//   rd_data         head entry (valid while !empty)
//   full, empty     status from the registered pointers
//   count           number of stored entries
// -----------------------------------------------------------------------------
module fpu_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign count   = wr_ptr - rd_ptr;
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr[AW-1:0]];

  // Pointer and storage update; write and pop in one cycle both take effect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= {(AW+1){1'b0}};
      rd_ptr <= {(AW+1){1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= {WIDTH{1'b0}};
      end
    end else begin
      if (do_wr) begin
        mem[wr_ptr[AW-1:0]] <= wr_data;
        wr_ptr              <= wr_ptr + {{AW{1'b0}}, 1'b1};
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
      end
    end
  end

endmodule : fpu_sync_fifo

// File: rtl/fpu_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// fpu_cmd_sequencer
// Sits between the register front end and the FPU datapath. Commands are
// queued in a command FIFO and issued one at a time; each produces exactly one
// entry in a result FIFO (FPU result, illegal-op marker or watchdog abort).
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   cmd_valid/cmd_ready           command handshake (ready = command FIFO not full)
//   cmd_op/sub/rm/a/b/c           command fields
//   fpu_req_valid/fpu_req_ready   issue handshake to the FPU
//   fpu_op/sub/rm/a/b/c           head command fields, stable while issuing
//   fpu_rsp_valid/data/exc        FPU response
//   res_valid/res_pop             result FIFO head present / pop
//   res_data, res_status          head result, status = {timeout, illegal, exc}
//   flags, flags_clr              sticky OR of result exceptions / clear
//   busy                          FSM active or commands still queued
// -----------------------------------------------------------------------------
module fpu_cmd_sequencer #(
  parameter int DATA_W    = 32,
  parameter int CMD_DEPTH = 4,
  parameter int RES_DEPTH = 4,
  parameter int OP_W      = 4,
  parameter int EXC_W     = 5,
  parameter int TIMEOUT   = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic [1:0]        cmd_sub,
  input  logic [2:0]        cmd_rm,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  input  logic [DATA_W-1:0] cmd_c,
  output logic              fpu_req_valid,
  input  logic              fpu_req_ready,
  output logic [OP_W-1:0]   fpu_op,
  output logic [1:0]        fpu_sub,
  output logic [2:0]        fpu_rm,
  output logic [DATA_W-1:0] fpu_a,
  output logic [DATA_W-1:0] fpu_b,
  output logic [DATA_W-1:0] fpu_c,
  input  logic              fpu_rsp_valid,
  input  logic [DATA_W-1:0] fpu_rsp_data,
  input  logic [EXC_W-1:0]  fpu_rsp_exc,
  output logic              res_valid,
  input  logic              res_pop,
  output logic [DATA_W-1:0] res_data,
  output logic [EXC_W+1:0]  res_status,
  output logic [EXC_W-1:0]  flags,
  input  logic              flags_clr,
  output logic              busy
);

  import fpu_pkg::OP_SINJ;
  import fpu_pkg::OP_CMP;
  import fpu_pkg::OP_LAST;
  import fpu_pkg::ST_IDLE;
  import fpu_pkg::ST_ISSUE;
  import fpu_pkg::ST_WAIT;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [1:0]        sub;
    logic [2:0]        rm;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] c;
  } cmd_t;

  typedef struct packed {
    logic              timeout;
    logic              illegal;
    logic [EXC_W-1:0]  exc;
    logic [DATA_W-1:0] data;
  } res_t;

  localparam int CMD_W = $bits(cmd_t);
  localparam int RES_W = $bits(res_t);
  localparam int WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  // Illegal: opcode beyond the datapath, or sign-inject/compare with sub-op 3.
  function automatic logic is_illegal(input logic [OP_W-1:0] op, input logic [1:0] sub);
    logic sub_checked;
    sub_checked = (op == OP_W'(OP_SINJ)) || (op == OP_W'(OP_CMP));
    return (op > OP_W'(OP_LAST)) || (sub_checked && (sub == 2'b11));
  endfunction

  cmd_t                       cmd_in;
  cmd_t                       cmd_head;
  logic                       cmd_full;
  logic                       cmd_empty;
  logic [$clog2(CMD_DEPTH):0] cmd_count;
  logic                       cmd_pop;

  res_t                       res_wdata;
  res_t                       res_head;
  logic                       res_full;
  logic                       res_empty;
  logic [$clog2(RES_DEPTH):0] res_count;
  logic                       res_push;
  logic [EXC_W-1:0]           res_exc;

  logic [1:0]                 state;
  logic [1:0]                 next_state;
  logic [WD_W-1:0]            wdog;
  logic                       wdog_clr;
  logic                       wdog_inc;
  logic                       can_start;
  logic                       head_illegal;
  logic                       issuing;
  logic                       unused_res_count;

  assign cmd_in = {cmd_op, cmd_sub, cmd_rm, cmd_a, cmd_b, cmd_c};

  fpu_sync_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (CMD_DEPTH)
  ) u_cmd_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (cmd_valid),
    .wr_data (cmd_in),
    .rd_en   (cmd_pop),
    .rd_data (cmd_head),
    .full    (cmd_full),
    .empty   (cmd_empty),
    .count   (cmd_count)
  );

  fpu_sync_fifo #(
    .WIDTH (RES_W),
    .DEPTH (RES_DEPTH)
  ) u_res_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (res_push),
    .wr_data (res_wdata),
    .rd_en   (res_pop),
    .rd_data (res_head),
    .full    (res_full),
    .empty   (res_empty),
    .count   (res_count)
  );

  assign unused_res_count = ^res_count;

  assign cmd_ready  = !cmd_full;
  assign fpu_op     = cmd_head.op;
  assign fpu_sub    = cmd_head.sub;
  assign fpu_rm     = cmd_head.rm;
  assign fpu_a      = cmd_head.a;
  assign fpu_b      = cmd_head.b;
  assign fpu_c      = cmd_head.c;
  assign res_valid  = !res_empty;
  assign res_data   = res_head.data;
  assign res_status = {res_head.timeout, res_head.illegal, res_head.exc};
  assign busy       = (state != ST_IDLE) || (cmd_count != {($clog2(CMD_DEPTH)+1){1'b0}});

  // Only the FSM writes results, so checking for room before issue guarantees
  // the slot is still free when the command completes.
  assign can_start    = !cmd_empty && !res_full;
  assign head_illegal = is_illegal(cmd_head.op, cmd_head.sub);
  assign res_exc      = res_push ? res_wdata.exc : {EXC_W{1'b0}};

  // Next-state, issue strobe and result-write decode.
  // A legal head is offered straight from IDLE so a push reaches the FPU on the
  // following cycle; ISSUE only holds the request while the FPU stalls.
  always_comb begin
    next_state    = state;
    cmd_pop       = 1'b0;
    res_push      = 1'b0;
    res_wdata     = '{timeout: 1'b0, illegal: 1'b0, exc: {EXC_W{1'b0}}, data: {DATA_W{1'b0}}};
    wdog_clr      = 1'b0;
    wdog_inc      = 1'b0;
    issuing       = 1'b0;
    fpu_req_valid = 1'b0;

    case (state)
      ST_IDLE: begin
        if (can_start && head_illegal) begin
          res_push          = 1'b1;
          res_wdata.illegal = 1'b1;
          cmd_pop           = 1'b1;
        end else if (can_start) begin
          issuing = 1'b1;
        end else begin
          next_state = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        issuing = 1'b1;
      end
      ST_WAIT: begin
        if (fpu_rsp_valid) begin
          res_push       = 1'b1;
          res_wdata.data = fpu_rsp_data;
          res_wdata.exc  = fpu_rsp_exc;
          cmd_pop        = 1'b1;
          next_state     = ST_IDLE;
        end else if (wdog == WD_W'(TIMEOUT - 1)) begin
          res_push          = 1'b1;
          res_wdata.timeout = 1'b1;
          cmd_pop           = 1'b1;
          next_state        = ST_IDLE;
        end else begin
          wdog_inc = 1'b1;
        end
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase

    if (issuing) begin
      fpu_req_valid = 1'b1;
      if (!fpu_req_ready) begin
        next_state = ST_ISSUE;
      end else if (fpu_rsp_valid) begin
        res_push       = 1'b1;
        res_wdata.data = fpu_rsp_data;
        res_wdata.exc  = fpu_rsp_exc;
        cmd_pop        = 1'b1;
        next_state     = ST_IDLE;
      end else begin
        wdog_clr   = 1'b1;
        next_state = ST_WAIT;
      end
    end else begin
      fpu_req_valid = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Watchdog: counts cycles spent in WAIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog <= {WD_W{1'b0}};
    end else if (wdog_clr) begin
      wdog <= {WD_W{1'b0}};
    end else if (wdog_inc) begin
      wdog <= wdog + {{(WD_W-1){1'b0}}, 1'b1};
    end else begin
      wdog <= wdog;
    end
  end

  // Sticky exception flags; a result written in the clear cycle still sets.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags <= {EXC_W{1'b0}};
    end else if (flags_clr) begin
      flags <= res_exc;
    end else begin
      flags <= flags | res_exc;
    end
  end

endmodule : fpu_cmd_sequencer

// File: tb/tb_fpu_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fpu_cmd_sequencer
// Directed self-checking bench for fpu_cmd_sequencer. Inputs change 1 time unit
// after the rising edge; outputs are sampled at that same point, away from it.
// -----------------------------------------------------------------------------
module tb_fpu_cmd_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op;
  logic [1:0]  cmd_sub;
  logic [2:0]  cmd_rm;
  logic [31:0] cmd_a;
  logic [31:0] cmd_b;
  logic [31:0] cmd_c;
  logic        fpu_req_valid;
  logic        fpu_req_ready;
  logic [3:0]  fpu_op;
  logic [1:0]  fpu_sub;
  logic [2:0]  fpu_rm;
  logic [31:0] fpu_a;
  logic [31:0] fpu_b;
  logic [31:0] fpu_c;
  logic        fpu_rsp_valid;
  logic [31:0] fpu_rsp_data;
  logic [4:0]  fpu_rsp_exc;
  logic        res_valid;
  logic        res_pop;
  logic [31:0] res_data;
  logic [6:0]  res_status;
  logic [4:0]  flags;
  logic        flags_clr;
  logic        busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fpu_cmd_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_op        (cmd_op),
    .cmd_sub       (cmd_sub),
    .cmd_rm        (cmd_rm),
    .cmd_a         (cmd_a),
    .cmd_b         (cmd_b),
    .cmd_c         (cmd_c),
    .fpu_req_valid (fpu_req_valid),
    .fpu_req_ready (fpu_req_ready),
    .fpu_op        (fpu_op),
    .fpu_sub       (fpu_sub),
    .fpu_rm        (fpu_rm),
    .fpu_a         (fpu_a),
    .fpu_b         (fpu_b),
    .fpu_c         (fpu_c),
    .fpu_rsp_valid (fpu_rsp_valid),
    .fpu_rsp_data  (fpu_rsp_data),
    .fpu_rsp_exc   (fpu_rsp_exc),
    .res_valid     (res_valid),
    .res_pop       (res_pop),
    .res_data      (res_data),
    .res_status    (res_status),
    .flags         (flags),
    .flags_clr     (flags_clr),
    .busy          (busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input logic [3:0] op, input logic [1:0] sub, input logic [31:0] a,
                         input logic [31:0] b);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_sub   = sub;
    cmd_rm    = 3'd0;
    cmd_a     = a;
    cmd_b     = b;
    cmd_c     = 32'h0;
  endtask

  task automatic pop_result();
    res_pop = 1'b1;
    tick();
    res_pop = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_op = 4'd0; cmd_sub = 2'd0; cmd_rm = 3'd0;
    cmd_a = 32'h0; cmd_b = 32'h0; cmd_c = 32'h0;
    fpu_req_ready = 1'b0; fpu_rsp_valid = 1'b0; fpu_rsp_data = 32'h0; fpu_rsp_exc = 5'h0;
    res_pop = 1'b0; flags_clr = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();

    // Reset state
    check("rst_busy", busy, 1'b0);
    check("rst_res_valid", res_valid, 1'b0);
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_req_valid", fpu_req_valid, 1'b0);
    check("rst_flags", flags, 5'h0);
    check("rst_res_data", res_data, 32'h0);
    check("rst_res_status", res_status, 7'h0);
    check("rst_fpu_a", fpu_a, 32'h0);

    // 1. Single-cycle add: request at N+1, result at N+2
    set_cmd(4'd6, 2'd0, 32'h3F800000, 32'h40000000);
    fpu_req_ready = 1'b1; fpu_rsp_valid = 1'b1; fpu_rsp_data = 32'h40400000; fpu_rsp_exc = 5'h0;
    tick();
    cmd_valid = 1'b0;
    check("t1_req_valid_n1", fpu_req_valid, 1'b1);
    check("t1_fpu_a", fpu_a, 32'h3F800000);
    check("t1_fpu_b", fpu_b, 32'h40000000);
    check("t1_fpu_op", fpu_op, 4'd6);
    check("t1_res_valid_n1", res_valid, 1'b0);
    tick();
    fpu_req_ready = 1'b0; fpu_rsp_valid = 1'b0;
    check("t1_res_valid_n2", res_valid, 1'b1);
    check("t1_res_data", res_data, 32'h40400000);
    check("t1_res_status", res_status, 7'h0);
    check("t1_req_idle", fpu_req_valid, 1'b0);
    pop_result();
    check("t1_popped", res_valid, 1'b0);

    // 2. Five back-to-back pushes while the FPU stalls; fifth refused
    for (int i = 0; i < 5; i++) begin
      set_cmd(4'd6, 2'd0, 32'(i + 1), 32'h0);
      check($sformatf("t2_cmd_ready_%0d", i), cmd_ready, (i < 4) ? 1'b1 : 1'b0);
      tick();
    end
    cmd_valid = 1'b0;
    check("t2_busy", busy, 1'b1);
    check("t2_hold_a", fpu_a, 32'h1);
    for (int k = 0; k < 4; k++) begin
      fpu_req_ready = 1'b1; fpu_rsp_valid = 1'b1; fpu_rsp_data = 32'hA0000000 + 32'(k);
      check($sformatf("t2_req_%0d", k), fpu_req_valid, 1'b1);
      check($sformatf("t2_order_a_%0d", k), fpu_a, 32'(k + 1));
      tick();
    end
    fpu_req_ready = 1'b0; fpu_rsp_valid = 1'b0;
    check("t2_drained_busy", busy, 1'b0);
    check("t2_drained_req", fpu_req_valid, 1'b0);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t2_res_%0d", k), res_data, 32'hA0000000 + 32'(k));
      pop_result();
    end
    check("t2_res_empty", res_valid, 1'b0);

    // 3. Divide answering after 20 cycles with DZ; then clear plus NX same cycle
    set_cmd(4'd9, 2'd0, 32'h40000000, 32'h0);
    fpu_req_ready = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    fpu_req_ready = 1'b0;
    for (int i = 0; i < 19; i++) tick();
    check("t3_waiting", res_valid, 1'b0);
    fpu_rsp_valid = 1'b1; fpu_rsp_data = 32'h7F800000; fpu_rsp_exc = 5'b01000;
    tick();
    fpu_rsp_valid = 1'b0; fpu_rsp_exc = 5'h0;
    check("t3_res_valid", res_valid, 1'b1);
    check("t3_res_data", res_data, 32'h7F800000);
    check("t3_res_status", res_status, 7'b0001000);
    check("t3_flags_dz", flags, 5'b01000);
    pop_result();
    set_cmd(4'd7, 2'd0, 32'h3F800000, 32'h3F800000);
    fpu_req_ready = 1'b1; fpu_rsp_valid = 1'b1; fpu_rsp_data = 32'h3F800001; fpu_rsp_exc = 5'b00001;
    tick();
    cmd_valid = 1'b0;
    flags_clr = 1'b1;
    tick();
    flags_clr = 1'b0; fpu_req_ready = 1'b0; fpu_rsp_valid = 1'b0; fpu_rsp_exc = 5'h0;
    check("t3_flags_set_wins", flags, 5'b00001);
    check("t3_status_nx", res_status, 7'b0000001);
    pop_result();
    flags_clr = 1'b1;
    tick();
    flags_clr = 1'b0;
    check("t3_flags_cleared", flags, 5'h0);

    // 4. Illegal compare sub-op and out-of-range opcode never reach the FPU
    set_cmd(4'd2, 2'b11, 32'h1234, 32'h5678);
    tick();
    set_cmd(4'd11, 2'b00, 32'h1, 32'h2);
    check("t4_no_req_cmp", fpu_req_valid, 1'b0);
    tick();
    cmd_valid = 1'b0;
    check("t4_no_req_op11", fpu_req_valid, 1'b0);
    check("t4_res_valid", res_valid, 1'b1);
    check("t4_res_data", res_data, 32'h0);
    check("t4_res_status", res_status, 7'b0100000);
    pop_result();
    check("t4_op11_status", res_status, 7'b0100000);
    check("t4_op11_busy", busy, 1'b0);
    pop_result();

    // 5. Sqrt never answers: abort after 64 WAIT cycles, then next command issues
    set_cmd(4'd10, 2'b00, 32'h40800000, 32'h0);
    fpu_req_ready = 1'b1;
    tick();
    set_cmd(4'd6, 2'd0, 32'h00000055, 32'h0);
    tick();
    cmd_valid = 1'b0; fpu_req_ready = 1'b0;
    check("t5_wait_req_low", fpu_req_valid, 1'b0);
    for (int i = 0; i < 63; i++) tick();
    check("t5_no_early_abort", res_valid, 1'b0);
    tick();
    check("t5_timeout_valid", res_valid, 1'b1);
    check("t5_timeout_status", res_status, 7'b1000000);
    check("t5_timeout_data", res_data, 32'h0);
    check("t5_next_issues", fpu_req_valid, 1'b1);
    check("t5_next_a", fpu_a, 32'h55);
    fpu_req_ready = 1'b1; fpu_rsp_valid = 1'b1; fpu_rsp_data = 32'h0BADF00D;
    tick();
    fpu_req_ready = 1'b0; fpu_rsp_valid = 1'b0;
    pop_result();
    check("t5_second_res", res_data, 32'h0BADF00D);
    pop_result();

    // 6. Reset during WAIT with two commands queued; late response ignored
    set_cmd(4'd9, 2'd0, 32'h1, 32'h2);
    fpu_req_ready = 1'b1;
    tick();
    fpu_req_ready = 1'b0;
    set_cmd(4'd6, 2'd0, 32'h3, 32'h4);
    tick();
    set_cmd(4'd7, 2'd0, 32'h5, 32'h6);
    tick();
    cmd_valid = 1'b0;
    check("t6_busy_before", busy, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_busy", busy, 1'b0);
    check("t6_res_valid", res_valid, 1'b0);
    check("t6_cmd_ready", cmd_ready, 1'b1);
    fpu_rsp_valid = 1'b1; fpu_rsp_data = 32'hDEADBEEF; fpu_rsp_exc = 5'b10000;
    tick();
    fpu_rsp_valid = 1'b0; fpu_rsp_exc = 5'h0;
    tick();
    check("t6_late_rsp_res", res_valid, 1'b0);
    check("t6_late_rsp_flags", flags, 5'h0);
    check("t6_req_idle", fpu_req_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_fpu_cmd_sequencer
